priority_irq_encoder: RTL

//   Parametrised, registered N-input priority encoder with sticky pending requests.

---
 rtl/priority_irq_encoder.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/priority_irq_encoder.sv
// Registered N-input priority encoder with sticky, edge-latched pending requests.
// Optional rotating priority is enabled by defining ROUND_ROBIN_EN.
module priority_irq_encoder #(
    parameter int N     = 8,
    parameter int IDX_W = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             out_ack,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_valid,
    output logic [N-1:0]     pend,
    output logic             any,
    output logic [CNT_W-1:0] drop_cnt
);
    localparam int PC_W  = $clog2(N + 1);
    localparam int SUM_W = CNT_W + PC_W + 1;

    typedef enum logic {IDLE = 1'b0, SHOW = 1'b1} state_t;

    state_t           state;
    state_t           state_d;
    logic [N-1:0]     req_q;
    logic [N-1:0]     ev;
    logic [N-1:0]     clr;
    logic [N-1:0]     lost;
    logic [N-1:0]     pend_d;
    logic [IDX_W-1:0] idx_d;
    logic [IDX_W-1:0] sel;
    logic [PC_W-1:0]  lost_cnt;
    logic [SUM_W-1:0] drop_sum;
    logic [CNT_W-1:0] drop_d;
    logic             ack_fire;

    // Handshake: out_idx is held while out_valid=1; a transfer happens on a
    // clock edge where out_valid & out_ack are both 1. out_ack is ignored otherwise.
    assign out_valid = (state == SHOW);
    assign any       = |pend;

    always_comb begin
        ack_fire = out_valid & out_ack;
        ev       = req & ~req_q;
        clr      = '0;
        for (int i = 0; i < N; i++) begin
            clr[i] = ack_fire && (out_idx == IDX_W'(i));
        end
        // An edge on a bit being cleared re-arms it rather than counting as lost.
        lost     = ev & pend & ~clr;
        pend_d   = ev | (pend & ~clr);
        lost_cnt = '0;
        for (int i = 0; i < N; i++) begin
            lost_cnt = lost_cnt + PC_W'(lost[i]);
        end
        drop_sum = SUM_W'(drop_cnt) + SUM_W'(lost_cnt);
        if (drop_sum > SUM_W'({CNT_W{1'b1}})) begin
            drop_d = '1;
        end else begin
            drop_d = drop_sum[CNT_W-1:0];
        end
    end

`ifdef ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ptr_d;
    logic [IDX_W-1:0] rr_j;

    // Scan ptr, ptr-1, ... with wrap; the last hit assigned (offset 0) wins.
    always_comb begin
        sel  = '0;
        rr_j = '0;
        for (int off = N - 1; off >= 0; off--) begin
            rr_j = IDX_W'((int'(ptr) - off + N) % N);
            if (pend[rr_j]) begin
                sel = rr_j;
            end
        end
    end

    always_comb begin
        ptr_d = ptr;
        if (ack_fire) begin
            ptr_d = (out_idx == '0) ? IDX_W'(N - 1) : out_idx - IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= IDX_W'(N - 1);
        end else begin
            ptr <= ptr_d;
        end
    end
`else
    always_comb begin
        sel = '0;
        for (int i = 0; i < N; i++) begin
            if (pend[i]) begin
                sel = IDX_W'(i);
            end
        end
    end
`endif

    // Selection looks at the registered pend, so a new edge takes two cycles to show.
    always_comb begin
        state_d = state;
        idx_d   = out_idx;
        case (state)
            IDLE: begin
                if (any) begin
                    idx_d   = sel;
                    state_d = SHOW;
                end
            end
            SHOW: begin
                if (out_ack) begin
                    idx_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                idx_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            out_idx  <= '0;
            pend     <= '0;
            req_q    <= '0;
            drop_cnt <= '0;
        end else begin
            state    <= state_d;
            out_idx  <= idx_d;
            pend     <= pend_d;
            req_q    <= req;
            drop_cnt <= drop_d;
        end
    end

endmodule
